// File: rtl/instr_fetch_stage_if.sv
// Bus bundle for the IF stage.
// Carries the loader byte stream, the HDU/branch control inputs and the
// IF/ID, status and performance outputs. The master modport is the
// surrounding pipeline/loader side. The slave modport is the fetch stage.
interface instr_fetch_stage_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 3
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              stall;
  logic              br_taken;
  logic [PC_W-1:0]   br_target;
  logic [DATA_W-1:0] if_id_instr;
  logic [PC_W-1:0]   if_id_pc;
  logic              if_id_valid;
  logic              running;
  logic              halted;
  logic [PC_W:0]     prog_len;
  logic [7:0]        perf_fetch;
  logic [7:0]        perf_stall;

  modport master (
    output load_valid, load_data, stall, br_taken, br_target,
    input  if_id_instr, if_id_pc, if_id_valid, running, halted,
           prog_len, perf_fetch, perf_stall
  );

  modport slave (
    input  load_valid, load_data, stall, br_taken, br_target,
    output if_id_instr, if_id_pc, if_id_valid, running, halted,
           prog_len, perf_fetch, perf_stall
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: IF stage of the 8-bit 5-stage pipeline.
// LOAD captures loader bytes into a local program buffer until 8'hFF or a full buffer.
// RUN fetches one instruction per cycle into IF/ID, honouring redirect and then stall.
// HALT is terminal until reset.
// Optional feature macro: FETCH_PERF_EN. It enables the saturating
// perf_fetch/perf_stall counters. When it is undefined, both outputs read 8'h00.
module instr_fetch_stage #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int PC_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam logic [DATA_W-1:0] END_BYTE = {DATA_W{1'b1}};
  localparam logic [PC_W:0]     DEPTH_L  = (PC_W + 1)'(DEPTH);
  localparam logic [PC_W:0]     LEN_ONE  = (PC_W + 1)'(1'b1);
  localparam logic [PC_W-1:0]   PTR_ONE  = PC_W'(1'b1);

  // pc is one bit wider than the buffer index so it can reach prog_len
  // (up to DEPTH) without wrapping back into the program.
  state_e            state_r, state_nxt_s;
  logic [PC_W-1:0]   wr_ptr_r, wr_ptr_nxt_s;
  logic [PC_W:0]     prog_len_r, prog_len_nxt_s;
  logic [PC_W:0]     pc_r, pc_nxt_s;
  logic [DATA_W-1:0] if_id_instr_r, if_id_instr_nxt_s;
  logic [PC_W-1:0]   if_id_pc_r, if_id_pc_nxt_s;
  logic              if_id_valid_r, if_id_valid_nxt_s;
  logic              running_r, halted_r;
  logic              mem_we_s;
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Next-state and datapath selection: LOAD capture, RUN priority (redirect > stall > fetch > halt).
  always_comb begin
    state_nxt_s       = state_r;
    wr_ptr_nxt_s      = wr_ptr_r;
    prog_len_nxt_s    = prog_len_r;
    pc_nxt_s          = pc_r;
    if_id_instr_nxt_s = if_id_instr_r;
    if_id_pc_nxt_s    = if_id_pc_r;
    if_id_valid_nxt_s = if_id_valid_r;
    mem_we_s          = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if_id_valid_nxt_s = 1'b0;
        if (bus.load_valid) begin
          if (bus.load_data == END_BYTE) begin
            state_nxt_s = ST_RUN;
          end else begin
            mem_we_s       = 1'b1;
            wr_ptr_nxt_s   = wr_ptr_r + PTR_ONE;
            prog_len_nxt_s = prog_len_r + LEN_ONE;
            // The byte that fills the buffer also starts execution.
            if (prog_len_r == (DEPTH_L - LEN_ONE)) begin
              state_nxt_s = ST_RUN;
            end else begin
              state_nxt_s = ST_LOAD;
            end
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (bus.br_taken) begin
          pc_nxt_s          = {1'b0, bus.br_target};
          if_id_instr_nxt_s = {DATA_W{1'b0}};
          if_id_valid_nxt_s = 1'b0;
        end else if (bus.stall) begin
          pc_nxt_s          = pc_r;
        end else if (pc_r < prog_len_r) begin
          if_id_instr_nxt_s = mem_r[pc_r[PC_W-1:0]];
          if_id_pc_nxt_s    = pc_r[PC_W-1:0];
          if_id_valid_nxt_s = 1'b1;
          pc_nxt_s          = pc_r + LEN_ONE;
        end else begin
          if_id_instr_nxt_s = {DATA_W{1'b0}};
          if_id_valid_nxt_s = 1'b0;
          state_nxt_s       = ST_HALT;
        end
      end
      ST_HALT: begin
        if_id_valid_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s       = ST_LOAD;
        if_id_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, pointers and IF/ID register; synchronous reset returns to LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_LOAD;
      wr_ptr_r      <= {PC_W{1'b0}};
      prog_len_r    <= {(PC_W + 1){1'b0}};
      pc_r          <= {(PC_W + 1){1'b0}};
      if_id_instr_r <= {DATA_W{1'b0}};
      if_id_pc_r    <= {PC_W{1'b0}};
      if_id_valid_r <= 1'b0;
      running_r     <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      wr_ptr_r      <= wr_ptr_nxt_s;
      prog_len_r    <= prog_len_nxt_s;
      pc_r          <= pc_nxt_s;
      if_id_instr_r <= if_id_instr_nxt_s;
      if_id_pc_r    <= if_id_pc_nxt_s;
      if_id_valid_r <= if_id_valid_nxt_s;
      running_r     <= (state_nxt_s == ST_RUN);
      halted_r      <= (state_nxt_s == ST_HALT);
    end
  end

  // Program buffer write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_r[wr_ptr_r] <= bus.load_data;
    end
  end

  assign bus.if_id_instr = if_id_instr_r;
  assign bus.if_id_pc    = if_id_pc_r;
  assign bus.if_id_valid = if_id_valid_r;
  assign bus.running     = running_r;
  assign bus.halted      = halted_r;
  assign bus.prog_len    = prog_len_r;

`ifdef FETCH_PERF_EN
  logic       fetch_evt_s;
  logic       stall_evt_s;
  logic [7:0] perf_fetch_r;
  logic [7:0] perf_stall_r;

  assign fetch_evt_s = (state_r == ST_RUN) && !bus.br_taken && !bus.stall &&
                       (pc_r < prog_len_r);
  assign stall_evt_s = (state_r == ST_RUN) && bus.stall && !bus.br_taken;

  // Saturating fetch and stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_r <= 8'h00;
      perf_stall_r <= 8'h00;
    end else begin
      if (fetch_evt_s && (perf_fetch_r != 8'hFF)) begin
        perf_fetch_r <= perf_fetch_r + 8'h01;
      end
      if (stall_evt_s && (perf_stall_r != 8'hFF)) begin
        perf_stall_r <= perf_stall_r + 8'h01;
      end
    end
  end

  assign bus.perf_fetch = perf_fetch_r;
  assign bus.perf_stall = perf_stall_r;
`else
  assign bus.perf_fetch = 8'h00;
  assign bus.perf_stall = 8'h00;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed testbench for instr_fetch_stage.
// Every expected value below is worked out by hand from the stage behaviour.
module tb_instr_fetch_stage;

  logic clk;
  logic rst;
  int   err_cnt;
  int   chk_cnt;

  instr_fetch_stage_if #(.DATA_W(8), .PC_W(3)) bus_if ();

  instr_fetch_stage #(.DATA_W(8), .DEPTH(8), .PC_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    bus_if.load_valid = 1'b1;
    bus_if.load_data  = b;
    tick();
    bus_if.load_valid = 1'b0;
    bus_if.load_data  = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] instr, input logic [2:0] pc);
    check_eq({tag, "_valid"}, bus_if.if_id_valid, 1'b1);
    check_eq({tag, "_instr"}, bus_if.if_id_instr, instr);
    check_eq({tag, "_pc"}, bus_if.if_id_pc, pc);
  endtask

  task automatic check_bubble(input string tag);
    check_eq({tag, "_valid"}, bus_if.if_id_valid, 1'b0);
    check_eq({tag, "_instr"}, bus_if.if_id_instr, 8'h00);
  endtask

  task automatic check_perf(input string tag, input logic [7:0] f, input logic [7:0] s);
`ifdef FETCH_PERF_EN
    check_eq({tag, "_perf_fetch"}, bus_if.perf_fetch, f);
    check_eq({tag, "_perf_stall"}, bus_if.perf_stall, s);
`else
    check_eq({tag, "_perf_fetch"}, bus_if.perf_fetch, 8'h00 & f);
    check_eq({tag, "_perf_stall"}, bus_if.perf_stall, 8'h00 & s);
`endif
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    rst = 1'b1;
    bus_if.load_valid = 1'b0;
    bus_if.load_data  = 8'h00;
    bus_if.stall      = 1'b0;
    bus_if.br_taken   = 1'b0;
    bus_if.br_target  = 3'd0;

    // Reset state.
    tick();
    tick();
    check_eq("rst_running", bus_if.running, 1'b0);
    check_eq("rst_halted", bus_if.halted, 1'b0);
    check_eq("rst_prog_len", bus_if.prog_len, 4'd0);
    check_eq("rst_pc", bus_if.if_id_pc, 3'd0);
    check_bubble("rst");
    check_perf("rst", 8'd0, 8'd0);
    rst = 1'b0;

    // Test 1: three-instruction program then halt.
    load_byte(8'h88);
    load_byte(8'h89);
    load_byte(8'h8A);
    check_eq("t1_load_running", bus_if.running, 1'b0);
    check_bubble("t1_load");
    load_byte(8'hFF);
    check_eq("t1_prog_len", bus_if.prog_len, 4'd3);
    check_eq("t1_running", bus_if.running, 1'b1);
    check_eq("t1_first_valid", bus_if.if_id_valid, 1'b0);
    tick(); check_out("t1_f0", 8'h88, 3'd0);
    tick(); check_out("t1_f1", 8'h89, 3'd1);
    tick(); check_out("t1_f2", 8'h8A, 3'd2);
    tick();
    check_eq("t1_halted", bus_if.halted, 1'b1);
    check_eq("t1_halt_running", bus_if.running, 1'b0);
    check_bubble("t1_halt");
    check_perf("t1", 8'd3, 8'd0);
    // HALT ignores stall, redirect and loader bytes.
    bus_if.stall = 1'b1; bus_if.br_taken = 1'b1; bus_if.br_target = 3'd0;
    bus_if.load_valid = 1'b1; bus_if.load_data = 8'h55;
    tick(); tick();
    bus_if.stall = 1'b0; bus_if.br_taken = 1'b0; bus_if.load_valid = 1'b0;
    check_eq("halt_sticky", bus_if.halted, 1'b1);
    check_eq("halt_valid", bus_if.if_id_valid, 1'b0);
    check_eq("halt_prog_len", bus_if.prog_len, 4'd3);
    check_perf("halt", 8'd3, 8'd0);

    // Tests 3/4: stall hold, redirect overriding stall, out-of-range redirect.
    do_reset();
    check_eq("t3_rst_prog_len", bus_if.prog_len, 4'd0);
    check_perf("t3_rst", 8'd0, 8'd0);
    load_byte(8'h88); load_byte(8'h89); load_byte(8'h8A); load_byte(8'hFF);
    tick(); check_out("t3_f0", 8'h88, 3'd0);
    tick(); check_out("t3_f1", 8'h89, 3'd1);
    bus_if.stall = 1'b1;
    tick(); check_out("t3_hold1", 8'h89, 3'd1);
    tick(); check_out("t3_hold2", 8'h89, 3'd1);
    bus_if.stall = 1'b0;
    tick(); check_out("t3_after", 8'h8A, 3'd2);
    check_perf("t3", 8'd3, 8'd2);
    bus_if.br_taken = 1'b1; bus_if.br_target = 3'd1; bus_if.stall = 1'b1;
    tick(); check_bubble("t4_bub_a");
    bus_if.br_taken = 1'b0; bus_if.stall = 1'b0;
    tick(); check_out("t4_tgt1", 8'h89, 3'd1);
    bus_if.br_taken = 1'b1; bus_if.br_target = 3'd0; bus_if.stall = 1'b1;
    tick(); check_bubble("t4_bub_b");
    bus_if.br_taken = 1'b0; bus_if.stall = 1'b0;
    tick(); check_out("t4_tgt0", 8'h88, 3'd0);
    tick(); check_out("t4_next", 8'h89, 3'd1);
    bus_if.br_taken = 1'b1; bus_if.br_target = 3'd5;
    tick(); check_bubble("t4_oob_bub");
    check_eq("t4_oob_running", bus_if.running, 1'b1);
    bus_if.br_taken = 1'b0;
    tick();
    check_eq("t4_oob_halted", bus_if.halted, 1'b1);
    check_bubble("t4_oob_halt");
    check_perf("t4", 8'd6, 8'd2);

    // Test 6: reset in mid-run, then a fresh program.
    do_reset();
    load_byte(8'h88); load_byte(8'h89); load_byte(8'h8A); load_byte(8'hFF);
    tick(); check_out("t6_f0", 8'h88, 3'd0);
    tick(); check_out("t6_f1", 8'h89, 3'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_running", bus_if.running, 1'b0);
    check_eq("t6_halted", bus_if.halted, 1'b0);
    check_eq("t6_prog_len", bus_if.prog_len, 4'd0);
    check_bubble("t6_rst");
    load_byte(8'h11); load_byte(8'h22); load_byte(8'hFF);
    check_eq("t6_new_len", bus_if.prog_len, 4'd2);
    tick(); check_out("t6_n0", 8'h11, 3'd0);
    tick(); check_out("t6_n1", 8'h22, 3'd1);
    tick(); check_eq("t6_new_halted", bus_if.halted, 1'b1);

    // Test 2: full buffer auto-starts, 9th byte ignored.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      check_eq("t2_not_running", bus_if.running, 1'b0);
      load_byte(8'(i));
    end
    check_eq("t2_running", bus_if.running, 1'b1);
    check_eq("t2_prog_len", bus_if.prog_len, 4'd8);
    bus_if.load_valid = 1'b1; bus_if.load_data = 8'h09;
    tick();
    bus_if.load_valid = 1'b0;
    check_out("t2_f0", 8'h01, 3'd0);
    check_eq("t2_len_after9", bus_if.prog_len, 4'd8);
    // Refetch slot 0: a stored 9th byte would have overwritten it.
    bus_if.br_taken = 1'b1; bus_if.br_target = 3'd0;
    tick(); check_bubble("t2_bub");
    bus_if.br_taken = 1'b0;
    tick(); check_out("t2_re0", 8'h01, 3'd0);
    for (int i = 2; i <= 8; i++) begin
      tick();
      check_out("t2_fn", 8'(i), 3'(i - 1));
    end
    tick();
    check_eq("t2_halted", bus_if.halted, 1'b1);
    check_perf("t2", 8'd9, 8'd0);

    // Test 5: empty program.
    do_reset();
    load_byte(8'hFF);
    check_eq("t5_running", bus_if.running, 1'b1);
    check_eq("t5_prog_len", bus_if.prog_len, 4'd0);
    check_bubble("t5_run");
    tick();
    check_eq("t5_halted", bus_if.halted, 1'b1);
    check_bubble("t5_halt");
    tick();
    check_eq("t5_still_invalid", bus_if.if_id_valid, 1'b0);
    check_perf("t5", 8'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
